// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the unified memory port arbiter (one instance per requester).
// master = requester (core or DMA), slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-transaction arbiter/sequencer sharing one synchronous memory port between core and DMA.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise core has strict priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  mem_port_arbiter_if.slave     core,
  mem_port_arbiter_if.slave     dma,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       owner;   // 0 = core, 1 = dma
  logic       cap_we;
  logic       win_dma;
  logic       grant;

  assign grant = resetn && (state == IDLE) && (core.req || dma.req);

`ifdef MEM_ARB_RR_EN
  logic last_dma;

  // On a tie the requester not served last wins; reset value lets core take the first tie.
  assign win_dma = dma.req && (!core.req || !last_dma);

  always_ff @(posedge clock) begin
    if (!resetn)    last_dma <= 1'b1;
    else if (grant) last_dma <= win_dma;
  end
`else
  assign win_dma = dma.req && !core.req;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:   if (grant) state_nxt = ACCESS;
      ACCESS: begin
        if (cap_we)                state_nxt = IDLE;
        else if (MEM_LATENCY == 1) state_nxt = RESP;
        else begin
          state_nxt = WAIT;
          cnt_nxt   = 4'(MEM_LATENCY - 1);
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      cap_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (grant) begin
        owner     <= win_dma;
        cap_we    <= win_dma ? dma.we    : core.we;
        mem_addr  <= win_dma ? dma.addr  : core.addr;
        mem_wdata <= win_dma ? dma.wdata : core.wdata;
      end
    end
  end

  assign mem_en      = (state == ACCESS);
  assign mem_we      = mem_en && cap_we;
  assign busy        = (state != IDLE);
  assign core.gnt    = grant && !win_dma;
  assign dma.gnt     = grant &&  win_dma;
  // Response is suppressed while reset is asserted so an aborted read never reports data.
  assign core.rvalid = resetn && (state == RESP) && !owner;
  assign dma.rvalid  = resetn && (state == RESP) &&  owner;
  assign core.rdata  = mem_rdata;
  assign dma.rdata   = mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: timing model from grant cycle, data from a shadow memory.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  initial forever #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) core_if ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dma_if ();

  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) u_dut (
    .clock     (clock),
    .resetn    (resetn),
    .core      (core_if),
    .dma       (dma_if),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 'h10) return 32'hDEADBEEF;
    return (32'(i) * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  // Synchronous memory macro with LAT-cycle read latency, persists across resets.
  logic [DW-1:0] mem [64];
  logic [DW-1:0] rd_pipe [LAT];
  logic          mem_init = 1'b0;
  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (mem_en && mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    rd_pipe[0] <= mem[mem_addr[5:0]];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } acc_t;
  typedef struct { bit own; logic [DW-1:0] data; } rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];

  // Reference model: everything follows from the cycle of the last grant.
  logic [DW-1:0] ref_mem [64];
  bit  ref_init = 0;
  int  cyc = 0, g_cyc = -100, busy_left = 0;
  bit  g_we = 0, g_own = 0, rr_last = 1, after_rst = 0;
  bit  eb, een, erv, cg, dg;
  int  core_gnt_cnt = 0, dma_gnt_cnt = 0;
  acc_t a;
  rsp_t r;

  initial forever begin
    @(negedge clock);
    if (!ref_init) begin
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      ref_init = 1;
    end
    if (!resetn) begin
      chk("gnt_in_reset", {core_if.gnt, dma_if.gnt}, 0);
      busy_left = 0; g_cyc = -100; rr_last = 1; after_rst = 1;
      acc_q.delete(); rsp_q.delete();
    end else begin
      if (after_rst) begin
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        after_rst = 0;
      end
      eb  = busy_left > 0;
      een = (cyc == g_cyc + 1);
      erv = !g_we && (cyc == g_cyc + 1 + LAT);
      cg = 0; dg = 0;
      if (!eb && (core_if.req || dma_if.req)) begin
`ifdef MEM_ARB_RR_EN
        dg = (core_if.req && dma_if.req) ? (rr_last == 0) : dma_if.req;
`else
        dg = !core_if.req;
`endif
        cg = !dg;
      end
      chk("core_gnt", core_if.gnt, cg);
      chk("dma_gnt", dma_if.gnt, dg);
      chk("busy", busy, eb);
      chk("mem_en", mem_en, een);
      chk("mem_we", mem_we, een && g_we);
      chk("core_rvalid", core_if.rvalid, erv && !g_own);
      chk("dma_rvalid", dma_if.rvalid, erv && g_own);
      if (mem_en) begin
        if (acc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_access: got unexpected access addr %0h expected none", mem_addr);
        end else begin
          a = acc_q.pop_front();
          chk("mem_addr", mem_addr, a.addr);
          chk("mem_wdata", mem_wdata, a.wdata);
        end
      end
      if (core_if.rvalid || dma_if.rvalid) begin
        if (rsp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp: got unexpected rvalid expected none");
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_owner", dma_if.rvalid, r.own);
          chk("rdata", dma_if.rvalid ? dma_if.rdata : core_if.rdata, r.data);
        end
      end
      if (cg || dg) begin
        a.we    = dg ? dma_if.we    : core_if.we;
        a.addr  = dg ? dma_if.addr  : core_if.addr;
        a.wdata = dg ? dma_if.wdata : core_if.wdata;
        acc_q.push_back(a);
        if (a.we) ref_mem[a.addr[5:0]] = a.wdata;
        else begin
          r.own = dg; r.data = ref_mem[a.addr[5:0]];
          rsp_q.push_back(r);
        end
        g_cyc = cyc; g_we = a.we; g_own = dg; rr_last = dg;
        busy_left = a.we ? 1 : LAT + 1;
      end else if (busy_left > 0) busy_left--;
    end
    if (core_if.gnt) core_gnt_cnt++;
    if (dma_if.gnt)  dma_gnt_cnt++;
    cyc++;
  end

  task automatic issue(input bit side, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    int seen;
    bit got = 0;
    seen = side ? dma_gnt_cnt : core_gnt_cnt;
    if (side) begin dma_if.we = we; dma_if.addr = ad; dma_if.wdata = d; dma_if.req = 1; end
    else begin core_if.we = we; core_if.addr = ad; core_if.wdata = d; core_if.req = 1; end
    for (int t = 0; t < 40 && !got; t++) begin
      @(posedge clock); #1;
      got = side ? (dma_gnt_cnt != seen) : (core_gnt_cnt != seen);
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL grant_timeout: got no grant expected grant for side %0d", side);
    end
    if (side) dma_if.req = 0; else core_if.req = 0;
  endtask

  int c_seen, d_seen;

  initial begin
    core_if.req = 0; core_if.we = 0; core_if.addr = '0; core_if.wdata = '0;
    dma_if.req  = 0; dma_if.we  = 0; dma_if.addr  = '0; dma_if.wdata  = '0;
    resetn = 0;
    repeat (3) @(posedge clock);
    #1 resetn = 1;

    issue(0, 0, 32'h10, 32'h0);              // core read of 0xDEADBEEF
    repeat (6) @(posedge clock); #1;
    issue(1, 1, 32'h20, 32'h12345678);       // dma write
    issue(1, 0, 32'h20, 32'h0);              // read it back
    repeat (6) @(posedge clock); #1;

    // Reset lands in the first WAIT cycle of a core read.
    issue(0, 0, 32'h05, 32'h0);
    @(posedge clock); #1 resetn = 0;
    @(posedge clock); #1 resetn = 1;
    issue(0, 0, 32'h10, 32'h0);
    repeat (6) @(posedge clock); #1;

    c_seen = core_gnt_cnt; d_seen = dma_gnt_cnt;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clock); #1;
      resetn = ($urandom_range(0, 399) != 0);
      if (core_gnt_cnt != c_seen) begin c_seen = core_gnt_cnt; core_if.req = 0; end
      else if (core_if.req && $urandom_range(0, 15) == 0) core_if.req = 0;
      if (!core_if.req && $urandom_range(0, 2) != 0) begin
        core_if.we = 1'($urandom_range(0, 1)); core_if.addr = 32'($urandom_range(0, 63));
        core_if.wdata = $urandom; core_if.req = 1;
      end
      if (dma_gnt_cnt != d_seen) begin d_seen = dma_gnt_cnt; dma_if.req = 0; end
      else if (dma_if.req && $urandom_range(0, 15) == 0) dma_if.req = 0;
      if (!dma_if.req && $urandom_range(0, 2) != 0) begin
        dma_if.we = 1'($urandom_range(0, 1)); dma_if.addr = 32'($urandom_range(0, 63));
        dma_if.wdata = $urandom; dma_if.req = 1;
      end
    end

    core_if.req = 0; dma_if.req = 0; resetn = 1;
    repeat (20) @(posedge clock);
    #1;
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("acc_q_drained", acc_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
